// File: rtl/keysw_io_ctrl.sv
// Memory-mapped KEY/SW input device: per-group 2-flop sync, debounce, sticky ready/overrun.
// Read data is combinational; read/write side effects commit on the clock edge.

module keysw_group #(
  parameter int W               = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_pin,
  input  logic         i_rd_data,
  input  logic         i_clr_ovr,
  output logic [W-1:0] o_deb,
  output logic         o_ready,
  output logic         o_ovr
);
  localparam int            CW    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] N_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]  r_sync1, r_sync2, r_cand, r_deb;
  logic [CW-1:0] r_cnt;
  logic          r_ready, r_ovr;
  logic          w_evt;

  assign w_evt = (r_sync2 == r_cand) && (r_cand != r_deb) && (r_cnt == N_MAX);

  // Synchronise the pins, then adopt a candidate once it has been stable long enough.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cand  <= '0;
      r_deb   <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= '0;
      end else if (r_cand != r_deb) begin
        if (r_cnt == N_MAX) begin
          r_deb <= r_cand;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // Sticky status: an event always raises ready; overrun set beats a same-edge clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ready <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_evt) begin
        r_ready <= 1'b1;
      end else if (i_rd_data) begin
        r_ready <= 1'b0;
      end else begin
        r_ready <= r_ready;
      end
      if (w_evt && r_ready && !i_rd_data) begin
        r_ovr <= 1'b1;
      end else if (i_clr_ovr) begin
        r_ovr <= 1'b0;
      end else begin
        r_ovr <= r_ovr;
      end
    end
  end

  assign o_deb   = r_deb;
  assign o_ready = r_ready;
  assign o_ovr   = r_ovr;
endmodule

module keysw_io_ctrl #(
  parameter int               DBITS           = 32,
  parameter logic [DBITS-1:0] ADDR_KDATA      = 32'hF0000010,
  parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF0000110,
  parameter logic [DBITS-1:0] ADDR_SDATA      = 32'hF0000014,
  parameter logic [DBITS-1:0] ADDR_SCTRL      = 32'hF0000114,
  parameter int               DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic             rdEn,
  input  logic             wrtEn,
  input  logic [DBITS-1:0] dIn,
  output logic [DBITS-1:0] dOut,
  output logic             sel,
  input  logic [3:0]       key,
  input  logic [9:0]       sw
);
  logic       w_hit_kd, w_hit_kc, w_hit_sd, w_hit_sc;
  logic [3:0] w_kdeb;
  logic [9:0] w_sdeb;
  logic       w_krdy, w_kovr, w_srdy, w_sovr;
  logic       w_unused_din;

  assign w_hit_kd     = (addr == ADDR_KDATA);
  assign w_hit_kc     = (addr == ADDR_KCTRL);
  assign w_hit_sd     = (addr == ADDR_SDATA);
  assign w_hit_sc     = (addr == ADDR_SCTRL);
  assign sel          = w_hit_kd | w_hit_kc | w_hit_sd | w_hit_sc;
  assign w_unused_din = ^{dIn[DBITS-1:3], dIn[1:0]};

  // KEY pins are active-low; invert so 1 means pressed.
  keysw_group #(.W(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
    .clk       (clk),
    .reset     (reset),
    .i_pin     (~key),
    .i_rd_data (rdEn & w_hit_kd),
    .i_clr_ovr (wrtEn & w_hit_kc & ~dIn[2]),
    .o_deb     (w_kdeb),
    .o_ready   (w_krdy),
    .o_ovr     (w_kovr)
  );

  keysw_group #(.W(10), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw (
    .clk       (clk),
    .reset     (reset),
    .i_pin     (sw),
    .i_rd_data (rdEn & w_hit_sd),
    .i_clr_ovr (wrtEn & w_hit_sc & ~dIn[2]),
    .o_deb     (w_sdeb),
    .o_ready   (w_srdy),
    .o_ovr     (w_sovr)
  );

  // Combinational read mux so the datapath can consume the value in the same cycle.
  always_comb begin
    dOut = '0;
    if (w_hit_kd) begin
      dOut = {{(DBITS-4){1'b0}}, w_kdeb};
    end else if (w_hit_kc) begin
      dOut = {{(DBITS-3){1'b0}}, w_kovr, 1'b0, w_krdy};
    end else if (w_hit_sd) begin
      dOut = {{(DBITS-10){1'b0}}, w_sdeb};
    end else if (w_hit_sc) begin
      dOut = {{(DBITS-3){1'b0}}, w_sovr, 1'b0, w_srdy};
    end else begin
      dOut = '0;
    end
  end
endmodule
